// File: rtl/sequenciador_consultas.sv
// sequenciador_consultas: queues path queries, runs the search core one at a time and streams the captured path back
module sequenciador_consultas #(
  parameter int ADDR_WIDTH = 12,
  parameter int CMD_DEPTH = 4,
  parameter int PATH_DEPTH = 256,
  parameter int TIMEOUT_CICLOS = 1000000,
  parameter bit ORDEM_DIRETA = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid_in,
  output logic                          cmd_ready_out,
  input  logic [ADDR_WIDTH-1:0]         cmd_fonte_in,
  input  logic [ADDR_WIDTH-1:0]         cmd_destino_in,
  output logic                          core_iniciar_out,
  output logic [ADDR_WIDTH-1:0]         core_fonte_out,
  output logic [ADDR_WIDTH-1:0]         core_destino_out,
  input  logic                          core_no_valido_in,
  input  logic [ADDR_WIDTH-1:0]         core_no_in,
  input  logic                          core_pronto_in,
  output logic                          res_valid_out,
  input  logic                          res_ready_in,
  output logic [ADDR_WIDTH-1:0]         res_no_out,
  output logic                          res_ultimo_out,
  output logic [1:0]                    res_codigo_out,
  output logic                          ocupado_out,
  output logic [$clog2(CMD_DEPTH):0]    pendentes_out
);
  localparam int CW = $clog2(CMD_DEPTH);
  localparam int PW = $clog2(PATH_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [PW:0] PD_MAX = (PW+1)'(PATH_DEPTH);
  typedef enum logic [1:0] {OCIOSO, INICIAR, COLETAR, ENTREGAR} estado_t;
  estado_t estado, prox;
  logic [2*ADDR_WIDTH-1:0] fila [CMD_DEPTH];
  logic [ADDR_WIDTH-1:0] buffer [PATH_DEPTH];
  logic [CW-1:0] wr_ptr, rd_ptr;
  logic [CW:0] ocup;
  logic [PW:0] conta, idx, rd_lin;
  logic [TW-1:0] tmo;
  logic tmo_flag, ovf_flag, push, pop, bypass, cap, fim_tmo, hs, ultimo;
  logic [ADDR_WIDTH-1:0] pop_fonte, pop_destino;
  logic [1:0] codigo;
  assign cmd_ready_out = ocup != (CW+1)'(CMD_DEPTH);
  assign pendentes_out = ocup;
  assign push = cmd_valid_in && cmd_ready_out;
  assign pop = estado == OCIOSO && ocup != '0;
  assign {pop_fonte, pop_destino} = fila[rd_ptr];
  assign bypass = pop_fonte == pop_destino;
  assign cap = estado == COLETAR && core_no_valido_in;
  assign fim_tmo = tmo == TW'(TIMEOUT_CICLOS - 1);
  assign hs = estado == ENTREGAR && res_ready_in;
  assign codigo = tmo_flag ? 2'd2 : ovf_flag ? 2'd3 : conta == '0 ? 2'd1 : 2'd0;
  assign ultimo = codigo != 2'd0 || idx == conta - 1'b1;
  assign rd_lin = ORDEM_DIRETA ? conta - 1'b1 - idx : idx;
  assign res_no_out = !res_valid_out || codigo != 2'd0 ? '0 : buffer[rd_lin[PW-1:0]];
  assign res_ultimo_out = res_valid_out && ultimo;
  assign res_codigo_out = res_valid_out ? codigo : 2'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) estado <= OCIOSO;
    else estado <= prox;
  always_comb begin
    prox = estado;
    core_iniciar_out = 1'b0;
    res_valid_out = 1'b0;
    ocupado_out = estado != OCIOSO;
    case (estado)
      OCIOSO: if (pop) prox = bypass ? ENTREGAR : INICIAR;
      INICIAR: begin
        core_iniciar_out = 1'b1;
        prox = COLETAR;
      end
      COLETAR: if (core_pronto_in || fim_tmo) prox = ENTREGAR;
      default: begin
        res_valid_out = 1'b1;
        if (res_ready_in && ultimo) prox = OCIOSO;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ocup <= '0;
      conta <= '0;
      idx <= '0;
      tmo <= '0;
      tmo_flag <= 1'b0;
      ovf_flag <= 1'b0;
      core_fonte_out <= '0;
      core_destino_out <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      ocup <= ocup + (CW+1)'(push) - (CW+1)'(pop);
      if (pop) begin
        idx <= '0;
        tmo_flag <= 1'b0;
        ovf_flag <= 1'b0;
        conta <= (PW+1)'(bypass);
        if (!bypass) begin
          core_fonte_out <= pop_fonte;
          core_destino_out <= pop_destino;
        end
      end
      if (estado == INICIAR) begin
        conta <= '0;
        tmo <= '0;
        ovf_flag <= 1'b0;
      end
      if (estado == COLETAR) begin
        tmo <= tmo + 1'b1;
        if (fim_tmo && !core_pronto_in) tmo_flag <= 1'b1;
        if (cap && conta != PD_MAX) conta <= conta + 1'b1;
        if (cap && conta == PD_MAX) ovf_flag <= 1'b1;
      end
      if (hs) idx <= idx + 1'b1;
    end
  always_ff @(posedge clk) begin
    if (push) fila[wr_ptr] <= {cmd_fonte_in, cmd_destino_in};
    if (pop && bypass) buffer[0] <= pop_fonte;
    else if (cap && conta != PD_MAX) buffer[conta[PW-1:0]] <= core_no_in;
  end
endmodule

// File: tb/tb_sequenciador_consultas.sv
// tb_sequenciador_consultas: drives both delivery orders side by side and checks them against a path/status model
module tb_sequenciador_consultas;
  localparam int AW = 12, CD = 4, PD = 8, TO = 40;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, core_nv = 0, core_pronto = 0, res_ready = 0;
  logic [AW-1:0] cmd_fonte = '0, cmd_destino = '0, core_no = '0;
  logic cmd_ready [2], core_ini [2], res_valid [2], res_ultimo [2], ocupado [2];
  logic [AW-1:0] core_f [2], core_d [2], res_no [2];
  logic [1:0] res_cod [2];
  logic [2:0] pend [2];
  for (genvar g = 0; g < 2; g++) begin : gd
    sequenciador_consultas #(.ADDR_WIDTH(AW), .CMD_DEPTH(CD), .PATH_DEPTH(PD),
      .TIMEOUT_CICLOS(TO), .ORDEM_DIRETA(g == 1)) u_dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid_in(cmd_valid), .cmd_ready_out(cmd_ready[g]),
      .cmd_fonte_in(cmd_fonte), .cmd_destino_in(cmd_destino), .core_iniciar_out(core_ini[g]),
      .core_fonte_out(core_f[g]), .core_destino_out(core_d[g]), .core_no_valido_in(core_nv),
      .core_no_in(core_no), .core_pronto_in(core_pronto), .res_valid_out(res_valid[g]),
      .res_ready_in(res_ready), .res_no_out(res_no[g]), .res_ultimo_out(res_ultimo[g]),
      .res_codigo_out(res_cod[g]), .ocupado_out(ocupado[g]), .pendentes_out(pend[g]));
  end
  always #5 clk = ~clk;
  int cyc = 0, n_ini = 0, exp_ini = 0, n_cmp = 0, n_err = 0, exp_code = 0;
  bit held_ok = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (core_ini[0]) n_ini <= n_ini + 1;
  logic [AW-1:0] nodes_q [$], exp0 [$], exp1 [$];
  localparam logic [63:0] RST_EXP = 64'({1'b0, 12'd0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b1, 12'd0, 12'd0});
  typedef struct { logic [AW-1:0] f, d; int nn; bit to, same; int mode, code; } vec_t;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  function automatic logic [63:0] outs(input int i);
    return 64'({res_valid[i], res_no[i], res_ultimo[i], res_cod[i], ocupado[i], core_ini[i],
                pend[i], cmd_ready[i], core_f[i], core_d[i]});
  endfunction
  // Reference: the core's node list is the path; status codes by priority; order 1 is the reverse.
  function automatic void model(input logic [AW-1:0] f, d, input bit to);
    exp0.delete();
    exp1.delete();
    exp_code = f == d ? 0 : to ? 2 : nodes_q.size() > PD ? 3 : nodes_q.size() == 0 ? 1 : 0;
    if (f == d) exp0.push_back(f);
    else if (exp_code != 0) exp0.push_back('0);
    else exp0 = nodes_q;
    foreach (exp0[i]) exp1.push_front(exp0[i]);
  endfunction
  task automatic push(input logic [AW-1:0] f, d, output int t);
    cmd_valid = 1; cmd_fonte = f; cmd_destino = d; t = -1;
    for (int i = 0; i < 300 && t < 0; i++) begin
      if (cmd_ready[0]) t = cyc;
      @(negedge clk);
    end
    cmd_valid = 0;
    if (t < 0) chk("push_accept", 0, 1);
  endtask
  task automatic collect(input int mode, input int first, output int last);
    int idx = 0, k = 0;
    bit seen = 0;
    last = -1;
    for (int c = 0; c < 300 && idx < exp0.size(); c++) begin
      @(negedge clk);
      core_nv = 0; core_pronto = 0;
      chk("valid_pair", res_valid[1], res_valid[0]);
      if (res_valid[0]) begin
        if (!seen) chk("first_beat_cycle", cyc, first);
        seen = 1;
        chk("no_ordem0", res_no[0], exp0[idx]);
        chk("no_ordem1", res_no[1], exp1[idx]);
        chk("ultimo", {res_ultimo[1], res_ultimo[0]}, {2{idx == exp0.size() - 1}});
        chk("codigo", {res_cod[1], res_cod[0]}, {2{exp_code[1:0]}});
      end
      res_ready = mode == 0 ? 1'b1 : mode == 1 ? k % 2 == 0 : 1'($urandom_range(0, 1));
      if (res_valid[0]) k++;
      if (res_valid[0] && res_ready) begin idx++; last = cyc; end
    end
    if (idx < exp0.size()) chk("collect_done", idx, exp0.size());
  endtask
  task automatic serve(input logic [AW-1:0] f, d, input int nn, input bit to, same,
                       input int start, mode, input bit rnd, input int code, output int last);
    int ini = -1, p;
    nodes_q.delete();
    for (int i = 0; i < nn; i++) nodes_q.push_back(rnd ? AW'($urandom) : d - AW'(2 * i));
    model(f, d, to);
    if (code >= 0) exp_code = code;
    if (f == d) p = start - 1;
    else begin
      for (int i = 0; i < 80 && ini < 0; i++) if (core_ini[0]) ini = cyc; else @(negedge clk);
      chk("iniciar_cycle", ini, start);
      chk("core_addr", {core_f[0], core_d[0]}, {f, d});
      exp_ini++;
      foreach (nodes_q[i]) begin
        @(negedge clk);
        core_nv = 1; core_no = nodes_q[i]; core_pronto = !to && same && i == nn - 1;
      end
      if (!to && !(same && nn > 0)) begin @(negedge clk); core_nv = 0; core_pronto = 1; end
      p = to ? ini + TO : cyc;
    end
    collect(mode, p + 1, last);
  endtask
  initial begin
    vec_t tab [9];
    logic [AW-1:0] qf [5], qd [5], f, d;
    int t, last, ini;
    tab[0] = '{12'd5, 12'd9, 3, 0, 0, 0, 0};
    tab[1] = '{12'd5, 12'd9, 3, 0, 0, 1, 0};
    tab[2] = '{12'd3, 12'd3, 0, 0, 0, 0, 0};
    tab[3] = '{12'd10, 12'd20, 0, 0, 0, 0, 1};
    tab[4] = '{12'd1, 12'd2, PD + 1, 0, 0, 0, 3};
    tab[5] = '{12'd1, 12'd2, PD, 0, 1, 2, 0};
    tab[6] = '{12'd4, 12'd7, 2, 1, 0, 0, 2};
    tab[7] = '{12'd4, 12'd7, 12, 1, 0, 0, 2};
    tab[8] = '{12'd6, 12'd8, 1, 0, 1, 0, 0};
    repeat (3) @(negedge clk);
    chk("reset_outs0", outs(0), RST_EXP);
    chk("reset_outs1", outs(1), RST_EXP);
    rst_n = 1;
    @(negedge clk);
    foreach (tab[i]) begin
      push(tab[i].f, tab[i].d, t);
      serve(tab[i].f, tab[i].d, tab[i].nn, tab[i].to, tab[i].same, t + 2, tab[i].mode, 0, tab[i].code, last);
    end
    repeat (25) begin
      f = AW'($urandom_range(0, 15));
      d = $urandom_range(0, 4) == 0 ? f : AW'($urandom_range(0, 15));
      push(f, d, t);
      serve(f, d, $urandom_range(0, PD + 2), $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), t + 2, 2, 1, -1, last);
    end
    // Hold one query in the core while the FIFO fills behind it.
    qf = '{12'd1, 12'd3, 12'd4, 12'd6, 12'd8};
    qd = '{12'd2, 12'd3, 12'd5, 12'd7, 12'd9};
    push(12'h11, 12'h22, t);
    nodes_q.delete();
    model(12'h11, 12'h22, 1);
    ini = -1;
    for (int i = 0; i < 80 && ini < 0; i++) if (core_ini[0]) ini = cyc; else @(negedge clk);
    chk("fifo_a_iniciar", ini, t + 2);
    exp_ini++;
    for (int j = 0; j < 4; j++) push(qf[j], qd[j], t);
    chk("fifo_full", {cmd_ready[0], pend[0]}, {1'b0, 3'd4});
    cmd_valid = 1; cmd_fonte = qf[4]; cmd_destino = qd[4];
    fork
      begin
        int tt = -1;
        for (int i = 0; i < 400 && tt < 0; i++) begin
          @(negedge clk);
          if (cmd_ready[0]) tt = cyc;
        end
        if (tt >= 0) @(negedge clk);
        cmd_valid = 0;
        held_ok = tt >= 0;
      end
    join_none
    @(negedge clk);
    chk("fifo_held", {cmd_ready[0], pend[0]}, {1'b0, 3'd4});
    collect(0, ini + TO + 1, last);
    for (int j = 0; j < 5; j++) serve(qf[j], qd[j], $urandom_range(0, 4), 0, 0, last + 2, 0, 1, -1, last);
    chk("fifth_accepted", held_ok, 1);
    // Abort a query during delivery with another command still queued.
    push(12'd5, 12'd9, t);
    push(12'd3, 12'd4, t);
    ini = -1;
    for (int i = 0; i < 80 && ini < 0; i++) if (core_ini[0]) ini = cyc; else @(negedge clk);
    exp_ini++;
    for (int i = 0; i < 3; i++) begin @(negedge clk); core_nv = 1; core_no = AW'(9 - 2 * i); end
    @(negedge clk);
    core_nv = 0; core_pronto = 1; res_ready = 0;
    @(negedge clk);
    core_pronto = 0;
    chk("valid_before_reset", {res_valid[0], pend[0]}, {1'b1, 3'd1});
    #2 rst_n = 0;
    #1 chk("async_reset0", outs(0), RST_EXP);
    chk("async_reset1", outs(1), RST_EXP);
    @(negedge clk);
    rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset", outs(0), RST_EXP);
    end
    chk("iniciar_pulses", n_ini, exp_ini);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
